// File: rtl/shift_scheduler.sv
// shift_scheduler: two-requester round-robin front end for a multi-cycle
// 5-bit left shifter. Each SHIFT cycle shifts by at most 3 positions, so an
// operation of total amount shamt takes ceil(shamt/3) SHIFT cycles, followed
// by a DONE state that holds the result until the consumer accepts it.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   reqN_valid/a/shamt/ready   requester N (N=0,1) operation handshake
//   res_valid/ready            result handshake
//   res_y                      shifted result (5 bits)
//   res_ovf                    a 1 bit was shifted out of the top
//   res_id                     requester owning the result
//   busy                       high while an operation is in SHIFT or DONE
module shift_scheduler #(
  parameter int unsigned SAW = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           req0_valid,
  input  logic [4:0]     req0_a,
  input  logic [SAW-1:0] req0_shamt,
  output logic           req0_ready,
  input  logic           req1_valid,
  input  logic [4:0]     req1_a,
  input  logic [SAW-1:0] req1_shamt,
  output logic           req1_ready,
  output logic           res_valid,
  input  logic           res_ready,
  output logic [4:0]     res_y,
  output logic           res_ovf,
  output logic           res_id,
  output logic           busy
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t         state, state_n;
  logic [4:0]     acc, acc_n;
  logic [SAW-1:0] rem, rem_n;
  logic           ovf, ovf_n;
  logic           id, id_n;
  logic           last, last_n;
  logic [4:0]     y_q, y_n;
  logic           rovf_q, rovf_n;
  logic           rid_q, rid_n;

  logic           gnt_any;
  logic           gnt;
  logic           accept;
  logic [4:0]     a_sel;
  logic [SAW-1:0] sh_sel;
  logic [1:0]     step;
  logic [7:0]     wide;

  // Round-robin: with both pending, grant the one not served last.
  always_comb begin
    gnt_any = req0_valid | req1_valid;
    gnt     = (req0_valid && req1_valid) ? ~last : ~req0_valid;
    accept  = rst_n && (state == IDLE) && gnt_any;
    a_sel   = gnt ? req1_a : req0_a;
    sh_sel  = gnt ? req1_shamt : req0_shamt;
  end

  // Ready is gated by rst_n so it stays low while reset is held.
  assign req0_ready = accept & ~gnt;
  assign req1_ready = accept &  gnt;

  // Shifting into an 8-bit window exposes the bits pushed out of the top.
  always_comb begin
    step = (rem > SAW'(2)) ? 2'd3 : rem[1:0];
    wide = {3'b000, acc} << step;
  end

  always_comb begin
    state_n = state;
    acc_n   = acc;
    rem_n   = rem;
    ovf_n   = ovf;
    id_n    = id;
    last_n  = last;
    y_n     = y_q;
    rovf_n  = rovf_q;
    rid_n   = rid_q;
    unique case (state)
      IDLE: begin
        if (accept) begin
          acc_n = a_sel;
          rem_n = sh_sel;
          ovf_n = 1'b0;
          id_n  = gnt;
          if (sh_sel == '0) begin
            state_n = DONE;
            y_n     = a_sel;
            rovf_n  = 1'b0;
            rid_n   = gnt;
          end else begin
            state_n = SHIFT;
          end
        end
      end
      SHIFT: begin
        acc_n = wide[4:0];
        ovf_n = ovf | (|wide[7:5]);
        rem_n = rem - SAW'(step);
        // Result registers are loaded on entry to DONE so they equal acc
        // there and keep their value once the FSM leaves DONE.
        if (rem_n == '0) begin
          state_n = DONE;
          y_n     = acc_n;
          rovf_n  = ovf_n;
          rid_n   = id;
        end
      end
      DONE: begin
        if (res_ready) begin
          state_n = IDLE;
          last_n  = id;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      acc    <= '0;
      rem    <= '0;
      ovf    <= 1'b0;
      id     <= 1'b0;
      last   <= 1'b1;
      y_q    <= '0;
      rovf_q <= 1'b0;
      rid_q  <= 1'b0;
    end else begin
      state  <= state_n;
      acc    <= acc_n;
      rem    <= rem_n;
      ovf    <= ovf_n;
      id     <= id_n;
      last   <= last_n;
      y_q    <= y_n;
      rovf_q <= rovf_n;
      rid_q  <= rid_n;
    end
  end

  assign res_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign res_y     = y_q;
  assign res_ovf   = rovf_q;
  assign res_id    = rid_q;

endmodule

// File: doc/shift_scheduler.md
SHIFT_SCHEDULER -- requirements
Module: shift_scheduler

Interface
REQ-001 SHALL have parameter SAW, default 3, shift-amount width; data width is fixed at 5 bits and each shift step is limited to 0..3 (2-bit step amount).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port req0_valid  input  1  requester 0 has an operation pending.
REQ-005 SHALL have port req0_a  input  5  requester 0 operand.
REQ-006 SHALL have port req0_shamt  input  SAW  requester 0 total left-shift amount.
REQ-007 SHALL have port req0_ready  output  1  requester 0 operation accepted this cycle.
REQ-008 SHALL have ports req1_valid, req1_a, req1_shamt, req1_ready, identical to REQ-004..REQ-007, for requester 1.
REQ-009 SHALL have port res_valid  output  1  result available.
REQ-010 SHALL have port res_ready  input  1  consumer accepts the result.
REQ-011 SHALL have port res_y  output  5  shifted result.
REQ-012 SHALL have port res_ovf  output  1  at least one 1 bit was shifted out.
REQ-013 SHALL have port res_id  output  1  requester that owns the result.
REQ-014 SHALL have port busy  output  1  high in SHIFT or DONE.

Function
REQ-015 SHALL implement an FSM with states IDLE, SHIFT and DONE.
REQ-016 In IDLE, the block SHALL grant exactly one valid requester; with both valid it SHALL grant the one not granted last (round-robin); with one valid it SHALL grant that one.
REQ-017 reqN_ready SHALL be combinational, high only in IDLE for the granted requester, and low in all other states.
REQ-018 On an accept edge, the block SHALL capture a into acc, shamt into rem and the requester into id, and SHALL clear ovf.
REQ-019 On an accept edge with shamt=0 the FSM SHALL go to DONE; otherwise it SHALL go to SHIFT.
REQ-020 In each SHIFT cycle: step = min(rem,3); acc <= acc << step, truncated to 5 bits; ovf <= ovf OR (any bit shifted out is 1); rem <= rem - step.
REQ-021 When rem - step = 0, the FSM SHALL go to DONE at that edge.
REQ-022 Number of SHIFT cycles = ceil(shamt/3); res_valid SHALL rise 1 + ceil(shamt/3) cycles after the accept edge.
REQ-023 In DONE: res_valid=1, and res_y=acc, res_ovf=ovf, res_id=id SHALL stay stable until res_ready=1.
REQ-024 On the DONE handshake edge, the FSM SHALL return to IDLE and the last-grant pointer SHALL update to id.
REQ-025 A new request SHALL be accepted no earlier than the cycle after the result handshake.
REQ-026 reqN_a/shamt changes after acceptance SHALL have no effect on the operation in flight.
REQ-027 res_valid SHALL be 0 in IDLE and SHIFT; res_y, res_ovf and res_id SHALL hold their last values outside DONE.

Reset
REQ-028 While rst_n=0, regardless of clock: state=IDLE, acc=0, rem=0, ovf=0, id=0, res_valid=0, res_y=0, res_ovf=0, res_id=0, busy=0, req0_ready=req1_ready=0.
REQ-029 The last-grant pointer SHALL reset to 1, so that requester 0 wins the first contention.
REQ-030 Reset asserted mid-SHIFT or mid-DONE SHALL abort the operation; the result SHALL be discarded and SHALL not be presented after release.
REQ-031 Operation SHALL resume on the first rising clk edge after rst_n rises.

Verification
REQ-032 Bench SHALL cover: req0 a=00011 shamt=2 -> 1 SHIFT cycle, res_y=01100, res_ovf=0, res_id=0, res_valid 2 cycles after accept.
REQ-033 Bench SHALL cover: req1 a=10101 shamt=7 -> steps 3,3,1; res_y=00000, res_ovf=1, res_id=1, res_valid 4 cycles after accept.
REQ-034 Bench SHALL cover: req0 a=10110 shamt=0 -> no SHIFT cycle, res_y=10110, res_ovf=0, res_valid 1 cycle after accept.
REQ-035 Bench SHALL cover: both requesters held valid from reset with res_ready=1 -> grants 0,1,0,1, with each ready pulse lasting exactly one cycle.
REQ-036 Bench SHALL cover: res_ready held low 4 cycles in DONE -> res_valid/res_y/res_ovf/res_id stable, both reqN_ready=0, busy=1.
REQ-037 Bench SHALL cover: rst_n pulsed low during SHIFT of shamt=7 -> all outputs 0 immediately, no res_valid after release, and the next contention is won by req0.
